skew_feeder: RTL and testbench
==============================

SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width in bits (signed).
REQ-002 Parameter ROWS, default 4, number of array rows fed (one shift register per row upstream).
REQ-003 Parameter LENGTH, default 4, elements per row per tile.
REQ-004 The block SHALL use one clock, clk; reset_n is asynchronous, active-low.
REQ-005 Port list, in this order:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous active-low reset.
- tile_in, input, signed DATA_WIDTH x [0:ROWS-1][0:LENGTH-1]: parallel tile taken from the upstream shift-register data_out vectors.
- load_valid, input, 1: tile_in is valid.
- load_ready, output, 1: block can accept a tile.
- array_en, input, 1: array advance enable; low stalls feeding.
- feed_data, output, signed DATA_WIDTH x [0:ROWS-1]: skewed row inputs to the systolic array edge.
- feed_valid, output, ROWS: per-row element valid.
- busy, output, 1: in FEED.
- done, output, 1: one-cycle completion pulse.

Function
REQ-006 Two states, IDLE and FEED; S = LENGTH+ROWS-1 steps per tile; step counter t is $clog2(S+1) bits wide.
REQ-007 IDLE: load_ready=1, busy=0; on a clock edge with load_valid=1, the block SHALL capture all of tile_in into an internal tile buffer, set t=0, and enter FEED.
REQ-008 FEED: load_ready=0, busy=1; load_valid and tile_in SHALL be ignored, and the buffer SHALL NOT change.
REQ-009 In FEED, on each edge with array_en=1 and t<S, for every r: feed_data[r] <= tile[r][t-r] and feed_valid[r] <= 1 when 0 <= t-r < LENGTH; otherwise feed_data[r] <= 0 and feed_valid[r] <= 0. Then t <= t+1.
REQ-010 In FEED, on each edge with array_en=0, t, feed_data, feed_valid and the buffer SHALL hold.
REQ-011 In FEED, on the edge with array_en=1 and t=S: feed_data <= 0, feed_valid <= 0, done <= 1, and state <= IDLE.
REQ-012 done SHALL be high for exactly one cycle and is cleared on the next edge regardless of array_en.
REQ-013 Latency: with array_en held high, the first valid element appears one cycle after the accept edge, and done rises S+1 cycles after the accept edge.
REQ-014 Row r SHALL be valid for exactly LENGTH consecutive non-stalled steps, starting at step r (diagonal skew).
REQ-015 Back-to-back operation: the cycle done is high, load_ready=1, so a new tile may be accepted on the following edge. No tile is accepted in the same edge that feeding completes.
REQ-016 Values SHALL pass through unmodified, signed, with no width change.
REQ-017 In IDLE, feed_data=0 and feed_valid=0 SHALL hold at all times.

Reset
REQ-018 reset_n low SHALL immediately, asynchronously to clk, force:
- state=IDLE, t=0, tile buffer all 0
- feed_data all 0, feed_valid all 0
- done=0, busy=0, load_ready=1
REQ-019 Reset mid-FEED SHALL abort the tile with no done pulse. After reset_n rises, the first edge with load_valid=1 is a normal accept.
REQ-020 Reset dominates load_valid and array_en in all cycles.

Verification (ROWS=LENGTH=4, DATA_WIDTH=8, S=7)
REQ-021 Basic skew: load tile[r][c]=10*r+c, array_en=1 -> feed_valid sequence per step = 0001, 0011, 0111, 1111, 1110, 1100, 1000. Row 2 outputs 20, 21, 22, 23 at steps 2-5. done at cycle 8 after accept.
REQ-022 Stall: array_en low for 3 cycles at step 3 -> outputs held unchanged for 3 cycles; done delayed by exactly 3 cycles; element order is unaffected.
REQ-023 Signed data: tile all -128 (0x80) -> every valid feed_data is 0x80, and invalid slots are 0x00.
REQ-024 Busy lockout: load_valid pulsed with a different tile at step 2 -> ignored; original tile is output intact, and load_ready stays 0 until done.
REQ-025 Back-to-back: second tile presented with load_valid held high -> accepted the cycle after done; its first valid element appears at row 0 one cycle later.
REQ-026 Async reset at step 4 (asserted between edges) -> outputs zero immediately, no done pulse; load_ready=1 after release.

Source files
------------

// File: rtl/skew_feeder.sv
// skew_feeder: accepts one ROWS x LENGTH tile from the upstream row shift
// registers and streams it into the systolic array edge with a diagonal skew,
// so that row r starts r steps after row 0. Feeding advances only while
// array_en is high; a single-cycle done pulse marks the end of each tile.
module skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int LENGTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic signed [DATA_WIDTH-1:0]  tile_in [0:ROWS-1][0:LENGTH-1],
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic                          array_en,
    output logic signed [DATA_WIDTH-1:0]  feed_data [0:ROWS-1],
    output logic [ROWS-1:0]               feed_valid,
    output logic                          busy,
    output logic                          done
);

    // Total skewed steps per tile, and the widths of the step and column indices.
    localparam int            S   = LENGTH + ROWS - 1;
    localparam int            TW  = $clog2(S + 1);
    localparam int            CW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [TW-1:0] S_T = TW'(S);

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [TW-1:0]                  t_q, t_d;
    logic signed [DATA_WIDTH-1:0]   tile_q [0:ROWS-1][0:LENGTH-1];
    logic signed [DATA_WIDTH-1:0]   tile_d [0:ROWS-1][0:LENGTH-1];
    logic signed [DATA_WIDTH-1:0]   feed_data_q [0:ROWS-1];
    logic signed [DATA_WIDTH-1:0]   feed_data_d [0:ROWS-1];
    logic [ROWS-1:0]                feed_valid_q, feed_valid_d;
    logic                           done_q, done_d;
    int                             idx;

    // Next-state logic: tile capture in IDLE, skewed stepping and completion in FEED.
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        tile_d       = tile_q;
        feed_data_d  = feed_data_q;
        feed_valid_d = feed_valid_q;
        done_d       = 1'b0;
        idx          = 0;

        case (state_q)
            IDLE: begin
                // Outputs stay quiet while idle; a valid tile is latched whole.
                for (int r = 0; r < ROWS; r++) begin
                    feed_data_d[r] = '0;
                end
                feed_valid_d = '0;
                if (load_valid) begin
                    tile_d  = tile_in;
                    t_d     = '0;
                    state_d = FEED;
                end
            end
            FEED: begin
                // A low array_en holds step, outputs and buffer untouched.
                if (array_en) begin
                    if (t_q == S_T) begin
                        for (int r = 0; r < ROWS; r++) begin
                            feed_data_d[r] = '0;
                        end
                        feed_valid_d = '0;
                        done_d       = 1'b1;
                        t_d          = '0;
                        state_d      = IDLE;
                    end else begin
                        // Row r presents column t-r while that column exists.
                        for (int r = 0; r < ROWS; r++) begin
                            idx = int'(t_q) - r;
                            if (idx >= 0 && idx < LENGTH) begin
                                feed_data_d[r]  = tile_q[r][idx[CW-1:0]];
                                feed_valid_d[r] = 1'b1;
                            end else begin
                                feed_data_d[r]  = '0;
                                feed_valid_d[r] = 1'b0;
                            end
                        end
                        t_d = t_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, step counter, tile buffer and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            t_q          <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < LENGTH; c++) begin
                    tile_q[r][c] <= '0;
                end
                feed_data_q[r] <= '0;
            end
            feed_valid_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            tile_q       <= tile_d;
            feed_data_q  <= feed_data_d;
            feed_valid_q <= feed_valid_d;
            done_q       <= done_d;
        end
    end

    assign feed_data  = feed_data_q;
    assign feed_valid = feed_valid_q;
    assign done       = done_q;
    assign busy       = (state_q == FEED);
    assign load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder with ROWS=LENGTH=4, DATA_WIDTH=8 (S=7).
module tb_skew_feeder;

    logic              clk;
    logic              reset_n;
    logic signed [7:0] tile [0:3][0:3];
    logic              load_valid;
    logic              load_ready;
    logic              array_en;
    logic signed [7:0] fd [0:3];
    logic [3:0]        fv;
    logic              busy;
    logic              done;

    int n_chk  = 0;
    int n_pass = 0;

    // Hand-derived per-step valid pattern and packed {r3,r2,r1,r0} data for tile 10*r+c.
    logic [3:0]  vtab [0:6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [31:0] dtab [0:6] = '{32'h00000000, 32'h00000A01, 32'h00140B02, 32'h1E150C03,
                                32'h1F160D00, 32'h20170000, 32'h21000000};

    skew_feeder #(.DATA_WIDTH(8), .ROWS(4), .LENGTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tile_in    (tile),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .array_en   (array_en),
        .feed_data  (fd),
        .feed_valid (fv),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] pk();
        return {fd[3], fd[2], fd[1], fd[0]};
    endfunction

    function automatic logic [31:0] const_exp(input logic [3:0] v, input logic [7:0] val);
        logic [31:0] e;
        e = '0;
        for (int r = 0; r < 4; r++) begin
            if (v[r]) e[8*r +: 8] = val;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                tile[r][c] = 8'(10 * r + c);
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                tile[r][c] = v;
    endtask

    task automatic step_ramp(input string tn, input int k);
        check($sformatf("%s_valid_s%0d", tn, k), {28'd0, fv}, {28'd0, vtab[k]});
        check($sformatf("%s_data_s%0d", tn, k), pk(), dtab[k]);
        check($sformatf("%s_nodone_s%0d", tn, k), {31'd0, done}, 32'd0);
    endtask

    task automatic accept(input string tn);
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check({tn, "_busy"}, {31'd0, busy}, 32'd1);
        check({tn, "_ready"}, {31'd0, load_ready}, 32'd0);
        check({tn, "_fv0"}, {28'd0, fv}, 32'd0);
    endtask

    task automatic finish_tile(input string tn);
        check({tn, "_done"}, {31'd0, done}, 32'd1);
        check({tn, "_done_fv"}, {28'd0, fv}, 32'd0);
        check({tn, "_done_fd"}, pk(), 32'd0);
        check({tn, "_done_ready"}, {31'd0, load_ready}, 32'd1);
        check({tn, "_done_busy"}, {31'd0, busy}, 32'd0);
        tick();
        check({tn, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        array_en   = 1'b0;
        set_const(8'h00);

        // Reset state
        #3;
        check("rst_ready", {31'd0, load_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fv", {28'd0, fv}, 32'd0);
        check("rst_fd", pk(), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_fv", {28'd0, fv}, 32'd0);

        // Basic skew: done 8 cycles after accept
        set_ramp();
        array_en = 1'b1;
        accept("basic");
        for (int k = 0; k < 7; k++) begin
            tick();
            step_ramp("basic", k);
        end
        tick();
        finish_tile("basic");

        // Stall three cycles after step 3
        accept("stall");
        for (int k = 0; k < 4; k++) begin
            tick();
            step_ramp("stall", k);
        end
        array_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            step_ramp("stall_hold", 3);
            check($sformatf("stall_busy_%0d", i), {31'd0, busy}, 32'd1);
        end
        array_en = 1'b1;
        for (int k = 4; k < 7; k++) begin
            tick();
            step_ramp("stall", k);
        end
        tick();
        finish_tile("stall");

        // Signed extreme: -128 everywhere
        set_const(8'h80);
        accept("sgn");
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("sgn_valid_s%0d", k), {28'd0, fv}, {28'd0, vtab[k]});
            check($sformatf("sgn_data_s%0d", k), pk(), const_exp(vtab[k], 8'h80));
        end
        tick();
        finish_tile("sgn");

        // Busy lockout: a different tile offered at step 2 is ignored
        set_ramp();
        accept("lock");
        for (int k = 0; k < 7; k++) begin
            if (k == 2) begin
                set_const(8'h55);
                load_valid = 1'b1;
            end
            tick();
            load_valid = 1'b0;
            step_ramp("lock", k);
            check($sformatf("lock_ready_s%0d", k), {31'd0, load_ready}, 32'd0);
        end
        tick();
        finish_tile("lock");

        // Back-to-back with load_valid held high throughout
        set_ramp();
        load_valid = 1'b1;
        tick();
        set_const(8'h7F);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            tick();
            step_ramp("b2b", k);
        end
        tick();
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_done_ready", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_done", {31'd0, done}, 32'd0);
        check("b2b_accept_fv", {28'd0, fv}, 32'd0);
        tick();
        check("b2b_first_fv", {28'd0, fv}, 32'h1);
        check("b2b_first_fd", pk(), 32'h0000007F);
        for (int k = 1; k < 5; k++) tick();
        check("b2b_s4_fv", {28'd0, fv}, 32'he);
        check("b2b_s4_fd", pk(), 32'h7F7F7F00);

        // Asynchronous reset between edges at step 4
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_fv", {28'd0, fv}, 32'd0);
        check("arst_fd", pk(), 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, load_ready}, 32'd1);
        check("arst_done", {31'd0, done}, 32'd0);
        load_valid = 1'b1;
        tick();
        check("arst_dominates", {31'd0, busy}, 32'd0);
        load_valid = 1'b0;
        reset_n    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("arst_nodone_%0d", i), {31'd0, done}, 32'd0);
        end
        check("arst_ready_after", {31'd0, load_ready}, 32'd1);
        set_ramp();
        accept("post");
        tick();
        step_ramp("post", 0);
        tick();
        step_ramp("post", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
